// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch prefetch stage.
// IF_BUS_ERR_EN adds a per-entry bus-error flag to fetch_entry_t.
package if_pkg;
    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam logic [31:0] NOP         = 32'h0000_0013;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
`ifdef IF_BUS_ERR_EN
        logic        err;
`endif
    } fetch_entry_t;
endpackage

// File: rtl/if_fifo.sv
// if_fifo: DEPTH-entry fetch buffer with synchronous flush and occupancy count.
// The head entry is read straight from storage; entries reset to RST_VAL so idle outputs are defined.
module if_fifo
    import if_pkg::*;
#(
    parameter int           DEPTH   = 4,
    parameter fetch_entry_t RST_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full;

    assign empty    = count == '0;
    assign full     = count == CW'(DEPTH);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // The credit scheme upstream must never let a response arrive with no free slot.
    assert property (@(posedge clk) disable iff (!reset_n) !(push && full && !flush));
endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: owns the fetch PC, issues imem requests under a DEPTH credit, buffers {pc,instr} for decode.
// Define IF_BUS_ERR_EN to add imem_err/out_err with the error carried per buffered instruction.
module if_prefetch
    import if_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
`ifdef IF_BUS_ERR_EN
    input  logic        imem_err,
    output logic        out_err,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);
    localparam int           CW        = $clog2(DEPTH) + 1;
    localparam logic [CW:0]  CAP       = (CW + 1)'(DEPTH);
    localparam fetch_entry_t RST_ENTRY = '{pc: RESET_PC, default: '0};

    logic [31:0]   fetch_pc, resp_pc, redirect_base;
    logic [CW-1:0] outstanding, outstanding_nxt, discard, fifo_count;
    logic          running, hs, push, pop, fifo_empty;
    fetch_entry_t  push_data, head;

    assign redirect_base   = redirect_pc & ~32'h3;
    // Responses still owed plus entries buffered may never exceed the buffer size.
    assign imem_req        = running && !redirect && ({1'b0, outstanding} + {1'b0, fifo_count} < CAP);
    assign imem_addr       = fetch_pc;
    assign hs              = imem_req && imem_gnt;
    assign outstanding_nxt = outstanding + CW'(hs) - CW'(imem_rvalid);
    assign push            = imem_rvalid && discard == '0 && !redirect;
    assign out_valid       = !fifo_empty && !redirect;
    assign pop             = out_valid && out_ready;
    assign out_pc          = head.pc;
    assign out_instr       = head.instr;
`ifdef IF_BUS_ERR_EN
    assign out_err         = head.err;
`endif

    always_comb begin
        push_data       = '0;
        push_data.pc    = resp_pc;
        push_data.instr = imem_rdata;
`ifdef IF_BUS_ERR_EN
        push_data.err   = imem_err;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running     <= 1'b0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            running     <= 1'b1;
            outstanding <= outstanding_nxt;
            if (redirect) begin
                // Everything still in flight belongs to the abandoned path.
                fetch_pc <= redirect_base;
                resp_pc  <= redirect_base;
                discard  <= outstanding_nxt;
            end else begin
                if (hs) fetch_pc <= fetch_pc + INSTR_BYTES;
                if (imem_rvalid) begin
                    if (discard != '0) discard <= discard - CW'(1);
                    else resp_pc <= resp_pc + INSTR_BYTES;
                end
            end
        end
    end

    if_fifo #(
        .DEPTH   (DEPTH),
        .RST_VAL (RST_ENTRY)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );
endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: vector table, hand-written corner sequences and a randomized run for if_prefetch.
// The reference tags each request with a redirect epoch and keeps only same-epoch responses.
module tb_if_prefetch;
    localparam int DEPTH = 4;

    logic        clk = 1'b0, reset_n = 1'b0, redirect = 1'b0, imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0, out_ready = 1'b0;
    logic [31:0] redirect_pc = '0, imem_rdata = '0;
    logic        imem_req, out_valid;
    logic [31:0] imem_addr, out_pc, out_instr;
`ifdef IF_BUS_ERR_EN
    logic        imem_err = 1'b0;
    logic        out_err;
`endif

    // ctl = {redirect, gnt, rvalid, ready}; ex = {expected imem_req, expected out_valid}
    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] rpc;
        logic [1:0]  ex;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
    } vec_t;
    typedef struct {
        logic [31:0] addr;
        int          ep;
    } req_t;

    req_t        q[$];
    logic [31:0] mq[$];
    logic [31:0] mfetch = '0;
    int          epoch = 0, tests = 0, fails = 0, hs_cnt = 0;
    logic        last_hs = 1'b0;
    vec_t        vt[20];
    vec_t        v;

    if_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
`ifdef IF_BUS_ERR_EN
        .imem_err    (imem_err),
        .out_err     (out_err),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
`ifdef IF_BUS_ERR_EN
        chk("rst_err", 32'(out_err), 32'd0);
`endif
        q.delete(); mq.delete(); mfetch = '0; epoch = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("release_req", 32'(imem_req), 32'd0);
    endtask

    task automatic cycle(input vec_t vv, input bit tbl);
        logic rd, g, rv, rdy, exp_req, exp_valid;
        req_t r;
        r = '{32'h0, 0};
        {rd, g, rv, rdy} = vv.ctl;
        @(negedge clk);
        rv = rv && q.size() > 0;
        redirect = rd; redirect_pc = vv.rpc; out_ready = rdy; imem_gnt = g; imem_rvalid = rv;
        if (rv) begin
            r = q.pop_front();
            imem_rdata = f(r.addr);
        end
`ifdef IF_BUS_ERR_EN
        imem_err = rv && r.addr == 32'h8;
`endif
        #1;
        exp_req   = !rd && (q.size() + (rv ? 1 : 0) + mq.size() < DEPTH);
        exp_valid = mq.size() > 0 && !rd;
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        chk("imem_addr", imem_addr, mfetch);
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid && out_valid) begin
            chk("out_pc", out_pc, mq[0]);
            chk("out_instr", out_instr, f(mq[0]));
`ifdef IF_BUS_ERR_EN
            chk("out_err", 32'(out_err), 32'(mq[0] == 32'h8));
`endif
        end
        if (tbl) begin
            chk("vec_req", 32'(imem_req), 32'(vv.ex[1]));
            chk("vec_addr", imem_addr, vv.e_addr);
            chk("vec_valid", 32'(out_valid), 32'(vv.ex[0]));
            if (vv.ex[0]) chk("vec_pc", out_pc, vv.e_pc);
        end
        last_hs = imem_req && g;
        if (rd) begin
            mq.delete();
            mfetch = vv.rpc & ~32'h3;
            epoch++;
        end else begin
            if (exp_valid && rdy) void'(mq.pop_front());
            if (rv && r.ep == epoch) mq.push_back(r.addr);
            if (exp_req && g) mfetch += 32'd4;
        end
        if (last_hs) q.push_back('{imem_addr, epoch});
    endtask

    initial begin
        vt[0]  = '{4'b0001, 32'h0,   2'b10, 32'h0,   32'h0};
        vt[1]  = '{4'b0001, 32'h0,   2'b10, 32'h0,   32'h0};
        vt[2]  = '{4'b0001, 32'h0,   2'b10, 32'h0,   32'h0};
        vt[3]  = '{4'b0101, 32'h0,   2'b10, 32'h0,   32'h0};
        vt[4]  = '{4'b0111, 32'h0,   2'b10, 32'h4,   32'h0};
        vt[5]  = '{4'b0111, 32'h0,   2'b11, 32'h8,   32'h0};
        vt[6]  = '{4'b0111, 32'h0,   2'b11, 32'hC,   32'h4};
        vt[7]  = '{4'b0101, 32'h0,   2'b11, 32'h10,  32'h8};
        vt[8]  = '{4'b1101, 32'h103, 2'b00, 32'h14,  32'h0};
        vt[9]  = '{4'b0011, 32'h0,   2'b10, 32'h100, 32'h0};
        vt[10] = '{4'b0111, 32'h0,   2'b10, 32'h100, 32'h0};
        vt[11] = '{4'b0111, 32'h0,   2'b10, 32'h104, 32'h0};
        vt[12] = '{4'b0011, 32'h0,   2'b11, 32'h108, 32'h100};
        vt[13] = '{4'b0001, 32'h0,   2'b11, 32'h108, 32'h104};
        vt[14] = '{4'b0101, 32'h0,   2'b10, 32'h108, 32'h0};
        vt[15] = '{4'b1111, 32'h200, 2'b00, 32'h10C, 32'h0};
        vt[16] = '{4'b0101, 32'h0,   2'b10, 32'h200, 32'h0};
        vt[17] = '{4'b0011, 32'h0,   2'b10, 32'h204, 32'h0};
        vt[18] = '{4'b0001, 32'h0,   2'b11, 32'h204, 32'h200};
        vt[19] = '{4'b0001, 32'h0,   2'b10, 32'h204, 32'h0};

        do_reset();
        for (int i = 0; i < 20; i++) cycle(vt[i], 1'b1);

        // full-rate stream: first instruction on the third cycle, then one per cycle
        do_reset();
        v = '{4'b0101, 32'h0, 2'b00, 32'h0, 32'h0};
        cycle(v, 1'b0);
        v.ctl = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            cycle(v, 1'b0);
            if (i >= 1) begin
                chk("stream_valid", 32'(out_valid), 32'd1);
                chk("stream_pc", out_pc, 32'((i - 1) * 4));
            end
        end

        // decode stalled: credit caps grants at DEPTH, then drains in order
        do_reset();
        hs_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            v.ctl = {1'b0, 1'b1, q.size() > 0, 1'b0};
            cycle(v, 1'b0);
            hs_cnt += int'(last_hs);
        end
        chk("cap_grants", 32'(hs_cnt), 32'(DEPTH));
        chk("cap_req", 32'(imem_req), 32'd0);
        v.ctl = 4'b0001;
        for (int i = 0; i < DEPTH; i++) begin
            cycle(v, 1'b0);
            chk("drain_pc", out_pc, 32'(i * 4));
        end

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            v.ctl = {$urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
                     $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7};
            v.rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            cycle(v, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
